// File: rtl/ring_flit_injector_pkg.sv
// Shared types and constants for the ring transmit path.
package ring_flit_injector_pkg;

  localparam int unsigned FLIT_W    = 64;
  localparam int unsigned NUM_FLITS = 9;
  localparam int unsigned PKT_W     = FLIT_W * NUM_FLITS;
  localparam int unsigned DEST_HI   = 55;
  localparam int unsigned DEST_LO   = 48;
  localparam int unsigned CNT_W     = $clog2(NUM_FLITS);

  typedef logic [PKT_W-1:0]  pkt_t;
  typedef logic [FLIT_W-1:0] flit_t;

  typedef enum logic [1:0] {
    IDLE,
    PASS,
    INJECT
  } tx_state_t;

  // Destination node address carried in flit 0.
  function automatic logic [7:0] pkt_dest(input pkt_t p);
    return p[DEST_HI:DEST_LO];
  endfunction

  // Flit select; indices past the last flit return zero.
  function automatic flit_t pkt_flit(input pkt_t p, input logic [CNT_W-1:0] idx);
    flit_t f;
    f = '0;
    for (int unsigned k = 0; k < NUM_FLITS; k++) begin
      if (idx == CNT_W'(k)) f = p[k*FLIT_W +: FLIT_W];
    end
    return f;
  endfunction

endpackage

// File: rtl/ring_flit_injector_fifo.sv
// Show-ahead packet queue between the core and the ring serializer.
module ring_pkt_fifo
  import ring_flit_injector_pkg::*;
#(
  parameter int unsigned QDEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_l,
  input  logic                    push_i,
  input  logic                    pop_i,
  input  pkt_t                    wdata_i,
  output pkt_t                    head_o,
  output logic [$clog2(QDEPTH):0] count_o,
  output logic                    full_o,
  output logic                    empty_o
);

  localparam int unsigned AW = $clog2(QDEPTH);
  localparam logic [AW:0] FULL_CNT = QDEPTH[AW:0];

  pkt_t          mem_q [QDEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // Gate requests by occupancy and compute the next fill level.
  always_comb begin
    do_push = push_i && !full_o;
    do_pop  = pop_i && !empty_o;
    count_d = count_q;
    if (do_push && !do_pop)      count_d = count_q + 1'b1;
    else if (!do_push && do_pop) count_d = count_q - 1'b1;
  end

  // Pointers and count; power-of-2 depth lets the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // Packet storage, no reset needed since count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/ring_flit_injector.sv
// Node transmit side: queues core packets, serializes them into flits and
// merges them with upstream through-traffic under a wormhole lock.
module ring_flit_injector
  import ring_flit_injector_pkg::*;
#(
  parameter int unsigned QDEPTH     = 4,
  parameter logic [7:0]  NODE_ID    = 8'd0,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                    clk,
  input  logic                    rst_l,
  input  pkt_t                    pkt_in,
  input  logic                    pkt_valid,
  output logic                    pkt_ready,
  input  logic [FLIT_W-1:0]       up_flit,
  input  logic                    up_valid,
  input  logic                    up_head,
  output logic                    up_ready,
  output logic [FLIT_W-1:0]       out_flit,
  output logic                    out_valid,
  output logic                    out_head,
  output logic                    out_tail,
  input  logic                    out_ready,
  output logic [$clog2(QDEPTH):0] q_count,
  output logic                    err_self
);

  localparam int unsigned SW = $clog2(STARVE_MAX + 1);

  tx_state_t        state_q;
  logic [CNT_W-1:0] flit_cnt_q;
  logic [SW-1:0]    starve_q;
  logic             err_q;

  pkt_t q_head;
  logic q_full, q_empty;
  logic pkt_accept, pkt_self, q_push, q_pop;
  logic xfer, is_tail, starve_hit;

  assign pkt_ready  = !q_full;
  assign pkt_accept = pkt_valid && pkt_ready;
  assign pkt_self   = (pkt_dest(pkt_in) == NODE_ID);
  assign q_push     = pkt_accept && !pkt_self;
  assign xfer       = out_valid && out_ready;
  assign is_tail    = (flit_cnt_q == CNT_W'(NUM_FLITS - 1));
  assign q_pop      = (state_q == INJECT) && xfer && is_tail;
  assign starve_hit = (starve_q == SW'(STARVE_MAX));
  assign err_self   = err_q;

  ring_pkt_fifo #(.QDEPTH(QDEPTH)) u_fifo (
    .clk     (clk),
    .rst_l   (rst_l),
    .push_i  (q_push),
    .pop_i   (q_pop),
    .wdata_i (pkt_in),
    .head_o  (q_head),
    .count_o (q_count),
    .full_o  (q_full),
    .empty_o (q_empty)
  );

  // Link mux: through-traffic, local flits, or nothing while deciding.
  always_comb begin
    out_flit  = '0;
    out_valid = 1'b0;
    out_head  = 1'b0;
    out_tail  = 1'b0;
    up_ready  = 1'b0;
    unique case (state_q)
      PASS: begin
        out_flit  = up_flit;
        out_valid = up_valid;
        up_ready  = out_ready;
        out_head  = (flit_cnt_q == '0);
        out_tail  = is_tail;
      end
      INJECT: begin
        out_flit  = pkt_flit(q_head, flit_cnt_q);
        out_valid = 1'b1;
        out_head  = (flit_cnt_q == '0);
        out_tail  = is_tail;
      end
      default: ;
    endcase
  end

  // Arbitration FSM, flit counter and starvation counter.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q    <= IDLE;
      flit_cnt_q <= '0;
      starve_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (up_valid && up_head && !(!q_empty && starve_hit)) state_q <= PASS;
          else if (!q_empty)                                   state_q <= INJECT;
        end
        PASS, INJECT: begin
          if (xfer) begin
            if (is_tail) begin
              flit_cnt_q <= '0;
              state_q    <= IDLE;
            end else begin
              flit_cnt_q <= flit_cnt_q + CNT_W'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase

      if (q_empty) begin
        starve_q <= '0;
      end else if (xfer && is_tail) begin
        if (state_q == INJECT)                     starve_q <= '0;
        else if (state_q == PASS && !starve_hit)   starve_q <= starve_q + SW'(1);
      end
    end
  end

  // Self-addressed packets are swallowed and flagged one cycle later.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) err_q <= 1'b0;
    else        err_q <= pkt_accept && pkt_self;
  end

  // Wormhole order: a head flit must not show up inside a worm being passed.
  assert property (@(posedge clk) disable iff (!rst_l)
    !(state_q == PASS && up_valid && up_head && flit_cnt_q != '0));

endmodule

// File: tb/tb_ring_flit_injector.sv
// Bench for ring_flit_injector: directed scenarios plus random traffic,
// all checked every cycle against a queue-based reference model.
module tb_ring_flit_injector;
  import ring_flit_injector_pkg::*;

  localparam int unsigned QD   = 4;
  localparam logic [7:0]  NID  = 8'd0;
  localparam int          SMAX = 4;

  logic              clk = 1'b0;
  logic              rst_l;
  pkt_t              pkt_in;
  logic              pkt_valid, pkt_ready;
  logic [FLIT_W-1:0] up_flit;
  logic              up_valid, up_head, up_ready;
  logic [FLIT_W-1:0] out_flit;
  logic              out_valid, out_head, out_tail, out_ready;
  logic [$clog2(QD):0] q_count;
  logic              err_self;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  ring_flit_injector #(.QDEPTH(QD), .NODE_ID(NID), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst_l(rst_l),
    .pkt_in(pkt_in), .pkt_valid(pkt_valid), .pkt_ready(pkt_ready),
    .up_flit(up_flit), .up_valid(up_valid), .up_head(up_head), .up_ready(up_ready),
    .out_flit(out_flit), .out_valid(out_valid), .out_head(out_head), .out_tail(out_tail),
    .out_ready(out_ready), .q_count(q_count), .err_self(err_self)
  );

  // Reference model: packet queue, current worm owner (0 none, 1 upstream, 2 local).
  pkt_t mq[$];
  int   m_mode, m_cnt, m_starve;
  bit   m_err;
  logic [63:0] e_flit;
  bit   e_valid, e_head, e_tail, e_upr, e_pktr, e_err;
  int   e_qc;

  // Observed link transfers.
  typedef struct { logic [63:0] f; bit h; bit t; int c; } obs_t;
  obs_t trace[$];

  // Stimulus generators.
  bit          up_busy, up_auto, pkt_auto, ordy_auto;
  int          up_idx;
  logic [63:0] up_base;
  int unsigned up_pct, up_gap, pkt_pct, self_pct, ordy_pct;

  function automatic logic [63:0] flit_of(input pkt_t p, input int k);
    return p[k*64 +: 64];
  endfunction

  // Packet whose flit k is base+k, with dest overwriting flit 0 bits 55:48.
  function automatic pkt_t make_pkt(input logic [63:0] base, input logic [7:0] dest);
    pkt_t p;
    for (int k = 0; k < NUM_FLITS; k++) p[k*64 +: 64] = base + 64'(k);
    p[55:48] = dest;
    return p;
  endfunction

  function automatic logic [63:0] expf(input logic [63:0] base, input logic [7:0] dest, input int k);
    logic [63:0] f;
    f = base + 64'(k);
    if (k == 0) f[55:48] = dest;
    return f;
  endfunction

  function automatic pkt_t rand_pkt(input int unsigned spct);
    pkt_t p;
    for (int k = 0; k < NUM_FLITS; k++) p[k*64 +: 64] = {$urandom, $urandom};
    p[55:48] = ($urandom_range(99) < spct) ? NID : 8'($urandom_range(255, 1));
    return p;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_expect();
    e_pktr = (mq.size() < QD);
    e_qc   = mq.size();
    e_err  = m_err;
    e_flit = '0; e_valid = 0; e_head = 0; e_tail = 0; e_upr = 0;
    if (m_mode == 1) begin
      e_flit = up_flit; e_valid = up_valid; e_upr = out_ready;
      e_head = (m_cnt == 0); e_tail = (m_cnt == NUM_FLITS - 1);
    end else if (m_mode == 2) begin
      e_flit = flit_of(mq[0], m_cnt); e_valid = 1;
      e_head = (m_cnt == 0); e_tail = (m_cnt == NUM_FLITS - 1);
    end
  endtask

  task automatic model_advance();
    bit xfer;
    int sz;
    bit nonempty;
    xfer = e_valid && out_ready;
    sz = mq.size();
    nonempty = (sz > 0);
    if (m_mode == 0) begin
      if (up_valid && up_head && !(nonempty && m_starve == SMAX)) m_mode = 1;
      else if (nonempty) m_mode = 2;
    end else if (xfer) begin
      if (m_cnt == NUM_FLITS - 1) begin
        if (m_mode == 2) begin
          void'(mq.pop_front());
          m_starve = 0;
        end else if (nonempty && m_starve < SMAX) begin
          m_starve++;
        end
        m_mode = 0;
        m_cnt = 0;
      end else begin
        m_cnt++;
      end
    end
    if (!nonempty) m_starve = 0;
    m_err = 0;
    if (pkt_valid && sz < QD) begin
      if (pkt_in[55:48] == NID) m_err = 1;
      else mq.push_back(pkt_in);
    end
  endtask

  task automatic check_all();
    chk("out_flit",  out_flit,  e_flit);
    chk("out_valid", 64'(out_valid), 64'(e_valid));
    chk("out_head",  64'(out_head),  64'(e_head));
    chk("out_tail",  64'(out_tail),  64'(e_tail));
    chk("up_ready",  64'(up_ready),  64'(e_upr));
    chk("pkt_ready", 64'(pkt_ready), 64'(e_pktr));
    chk("q_count",   64'(q_count),   64'(e_qc));
    chk("err_self",  64'(err_self),  64'(e_err));
  endtask

  task automatic drive_up();
    up_valid = up_busy && ($urandom_range(99) >= up_gap);
    up_head  = up_busy && (up_idx == 0);
    up_flit  = up_busy ? up_base + 64'(up_idx) : '0;
  endtask

  task automatic start_worm(input logic [63:0] base);
    up_busy = 1; up_idx = 0; up_base = base;
    drive_up();
  endtask

  task automatic push_pkt(input pkt_t p);
    pkt_in = p; pkt_valid = 1;
  endtask

  // One clock cycle: check outputs on the falling edge, advance everything after the rising edge.
  task automatic step();
    bit up_x, pk_x;
    model_expect();
    @(negedge clk);
    check_all();
    if (out_valid === 1'b1 && out_ready === 1'b1)
      trace.push_back('{f: out_flit, h: out_head, t: out_tail, c: cyc});
    up_x = up_valid && e_upr;
    pk_x = pkt_valid && e_pktr;
    model_advance();
    @(posedge clk);
    #1;
    cyc++;
    if (pk_x) pkt_valid = 0;
    if (up_x) begin
      up_idx++;
      if (up_idx == NUM_FLITS) up_busy = 0;
    end
    if (!up_busy && up_auto && $urandom_range(99) < up_pct)
      start_worm({8'hBB, 24'($urandom), $urandom});
    else
      drive_up();
    if (!pkt_valid && pkt_auto && $urandom_range(99) < pkt_pct) push_pkt(rand_pkt(self_pct));
    if (ordy_auto) out_ready = ($urandom_range(99) < ordy_pct);
  endtask

  task automatic clear_all();
    mq.delete(); m_mode = 0; m_cnt = 0; m_starve = 0; m_err = 0;
    up_busy = 0; up_idx = 0; up_base = '0;
    up_auto = 0; pkt_auto = 0; ordy_auto = 0; up_gap = 0;
    pkt_valid = 0; pkt_in = '0; up_valid = 0; up_head = 0; up_flit = '0; out_ready = 0;
  endtask

  task automatic do_reset();
    rst_l = 0;
    clear_all();
    #3;
    model_expect();
    check_all();
    @(posedge clk); @(posedge clk);
    #2 rst_l = 1;
    @(posedge clk); #1;
  endtask

  initial begin
    int c0;
    pkt_t p;
    do_reset();

    // 1: single inject, one bubble, nine flits in order.
    out_ready = 1;
    trace.delete();
    c0 = cyc;
    push_pkt(make_pkt(64'hA0, 8'd3));
    step();
    chk("t1_qcount_after_push", 64'(q_count), 64'd1);
    repeat (12) step();
    chk("t1_nflits", 64'(trace.size()), 64'd9);
    for (int k = 0; k < 9 && k < trace.size(); k++) begin
      chk("t1_flit", trace[k].f, (k == 0) ? 64'h0003_0000_0000_00A0 : 64'hA0 + 64'(k));
      chk("t1_head", 64'(trace[k].h), 64'(k == 0));
      chk("t1_tail", 64'(trace[k].t), 64'(k == 8));
      chk("t1_cycle", 64'(trace[k].c), 64'(c0 + 2 + k));
    end
    chk("t1_qcount_end", 64'(q_count), 64'd0);

    // 2: upstream head and core packet together -> pass first, bubble, then inject.
    trace.delete();
    c0 = cyc;
    start_worm(64'hB100_0000_0000_0000);
    push_pkt(make_pkt(64'hC100_0000_0000_0000, 8'd5));
    repeat (25) step();
    chk("t2_nflits", 64'(trace.size()), 64'd18);
    if (trace.size() == 18) begin
      for (int k = 0; k < 9; k++) begin
        chk("t2_pass_flit", trace[k].f, 64'hB100_0000_0000_0000 + 64'(k));
        chk("t2_inj_flit", trace[9+k].f, expf(64'hC100_0000_0000_0000, 8'd5, k));
      end
      chk("t2_pass_start", 64'(trace[0].c), 64'(c0 + 1));
      chk("t2_bubble", 64'(trace[9].c), 64'(trace[8].c + 2));
    end

    // 3: continuous upstream worms vs. one queued local packet.
    trace.delete();
    up_auto = 1; up_pct = 100; up_gap = 0;
    start_worm({8'hBB, 24'($urandom), $urandom});
    push_pkt(make_pkt(64'hCC00_0000_0000_0000, 8'd5));
    repeat (60) step();
    up_auto = 0;
    repeat (30) step();
    begin
      int idx;
      idx = -1;
      for (int i = 0; i < trace.size(); i++)
        if (idx < 0 && trace[i].f == expf(64'hCC00_0000_0000_0000, 8'd5, 0)) idx = i;
      chk("t3_pass_flits_before_inject", 64'(idx), 64'd36);
      if (idx >= 0 && idx + 9 <= trace.size())
        for (int k = 0; k < 9; k++)
          chk("t3_inj_flit", trace[idx+k].f, expf(64'hCC00_0000_0000_0000, 8'd5, k));
    end

    // 4: stall for three cycles at flit 4 of an inject.
    trace.delete();
    out_ready = 1;
    push_pkt(make_pkt(64'hD000_0000_0000_00D0, 8'd7));
    step(); step();
    repeat (4) step();
    out_ready = 0;
    repeat (3) begin
      chk("t4_hold_flit", out_flit, 64'hD000_0000_0000_00D4);
      step();
    end
    out_ready = 1;
    repeat (8) step();
    chk("t4_nflits", 64'(trace.size()), 64'd9);
    for (int k = 0; k < 9 && k < trace.size(); k++)
      chk("t4_flit", trace[k].f, expf(64'hD000_0000_0000_00D0, 8'd7, k));

    // 5: fill the queue with the link blocked; fifth packet waits.
    trace.delete();
    out_ready = 0;
    for (int i = 0; i < 4; i++) begin
      push_pkt(make_pkt(64'hE000_0000_0000_0000 + (64'(i) << 32), 8'd9));
      step();
    end
    chk("t5_qcount_full", 64'(q_count), 64'd4);
    chk("t5_not_ready", 64'(pkt_ready), 64'd0);
    push_pkt(make_pkt(64'hE000_0000_0000_0000 + (64'd4 << 32), 8'd9));
    repeat (3) step();
    chk("t5_still_full", 64'(q_count), 64'd4);
    chk("t5_still_not_ready", 64'(pkt_ready), 64'd0);
    out_ready = 1;
    for (int i = 0; i < 100 && (mq.size() > 0 || pkt_valid || m_mode != 0); i++) step();
    chk("t5_drained_q", 64'(q_count), 64'd0);
    chk("t5_nflits", 64'(trace.size()), 64'd45);
    for (int i = 0; i < 5; i++)
      for (int k = 0; k < 9; k++)
        if (i*9 + k < trace.size())
          chk("t5_flit", trace[i*9+k].f, expf(64'hE000_0000_0000_0000 + (64'(i) << 32), 8'd9, k));

    // 6a: self-addressed packet is swallowed with an error pulse.
    trace.delete();
    push_pkt(make_pkt(64'hF000_0000_0000_0000, NID));
    step();
    chk("t6_err_pulse", 64'(err_self), 64'd1);
    chk("t6_qcount", 64'(q_count), 64'd0);
    chk("t6_no_valid", 64'(out_valid), 64'd0);
    step();
    chk("t6_err_clear", 64'(err_self), 64'd0);
    repeat (3) step();
    chk("t6_no_flits", 64'(trace.size()), 64'd0);

    // 6b: asynchronous reset in the middle of an inject.
    p = make_pkt(64'hF100_0000_0000_0000, 8'd2);
    push_pkt(p);
    step();
    push_pkt(make_pkt(64'hF200_0000_0000_0000, 8'd2));
    for (int i = 0; i < 20 && !(m_mode == 2 && m_cnt == 5); i++) step();
    chk("t6_at_flit5", out_flit, 64'hF100_0000_0000_0005);
    #2 rst_l = 0;
    #1;
    chk("t6_rst_out_valid", 64'(out_valid), 64'd0);
    chk("t6_rst_out_flit", out_flit, 64'd0);
    chk("t6_rst_out_head", 64'(out_head), 64'd0);
    chk("t6_rst_out_tail", 64'(out_tail), 64'd0);
    chk("t6_rst_up_ready", 64'(up_ready), 64'd0);
    chk("t6_rst_q_count", 64'(q_count), 64'd0);
    chk("t6_rst_pkt_ready", 64'(pkt_ready), 64'd1);
    chk("t6_rst_err_self", 64'(err_self), 64'd0);
    do_reset();
    trace.delete();
    out_ready = 1;
    repeat (12) step();
    chk("t6_flushed", 64'(trace.size()), 64'd0);

    // Random traffic against the model.
    up_auto = 1; up_pct = 30; up_gap = 20;
    pkt_auto = 1; pkt_pct = 40; self_pct = 10;
    ordy_auto = 1; ordy_pct = 75;
    repeat (3000) step();
    up_auto = 0; pkt_auto = 0; ordy_auto = 0; out_ready = 1;
    for (int i = 0; i < 200 && (mq.size() > 0 || pkt_valid || up_busy || m_mode != 0); i++) step();
    chk("rand_drained_q", 64'(q_count), 64'd0);
    chk("rand_drained_valid", 64'(out_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
